// File: rtl/uart_pixel_loader_pkg.sv
// Shared definitions for the image write path: loader states, default sizes
// and RGB565 field positions used by both the loader and the grayscale reader.
package uart_pixel_loader_pkg;

   typedef enum logic [1:0] {
      WAIT_HI = 2'd0,
      WAIT_LO = 2'd1,
      DONE    = 2'd2
   } load_state_e;

   localparam int ADDR_W_DEF      = 18;
   localparam int TIMEOUT_CYC_DEF = 100000;

   localparam int RGB_R_MSB = 15;
   localparam int RGB_R_LSB = 11;
   localparam int RGB_G_MSB = 10;
   localparam int RGB_G_LSB = 5;
   localparam int RGB_B_MSB = 4;
   localparam int RGB_B_LSB = 0;

   // Pixels arrive big-endian: first byte on the wire is the upper half.
   function automatic logic [15:0] rgb565_pack(input logic [7:0] hi_byte,
                                               input logic [7:0] lo_byte);
      return {hi_byte, lo_byte};
   endfunction

endpackage

// File: rtl/uart_pixel_loader_byte_timeout.sv
// Loadable down-counter with synchronous clear and count enable; expire is
// high while enabled with the count at zero.
module uart_pixel_loader_byte_timeout #(
   parameter int CNT_W = 17
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             load,
   input  logic             en,
   input  logic [CNT_W-1:0] load_val,
   output logic             expire
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (load) begin
         cnt_d = load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   assign expire = en && !clr && !load && (cnt_q == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_pixel_loader.sv
// Pairs UART bytes into RGB565 pixels and writes them to sequential image RAM
// addresses, resynchronising on an inter-byte timeout and holding once full.
//
// state   | meaning
// WAIT_HI | idle, next byte is a pixel's high byte
// WAIT_LO | high byte held, waiting for low byte or timeout
// DONE    | frame full, bytes ignored until clr or reset
module uart_pixel_loader
   import uart_pixel_loader_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [15:0]       wr_data,
   output logic              load_done,
   output logic              sync_err
);

   localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

   load_state_e       state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        hi_q, hi_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [15:0]       wr_data_q, wr_data_d;
   logic              done_q, done_d;
   logic              sync_err_q, sync_err_d;

   logic tmo_load;
   logic tmo_en;
   logic tmo_expire;

   assign tmo_load = !clr && (state_q == WAIT_HI) && rx_valid;
   assign tmo_en   = !clr && (state_q == WAIT_LO) && !rx_valid;

   uart_pixel_loader_byte_timeout #(
      .CNT_W (CNT_W)
   ) u_byte_timeout (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .load     (tmo_load),
      .en       (tmo_en),
      .load_val (CNT_W'(TIMEOUT_CYC - 1)),
      .expire   (tmo_expire)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      hi_d       = hi_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      done_d     = done_q;
      sync_err_d = 1'b0;
      if (clr) begin
         state_d = WAIT_HI;
         addr_d  = '0;
         done_d  = 1'b0;
      end else begin
         case (state_q)
            WAIT_HI: begin
               if (rx_valid) begin
                  hi_d    = rx_data;
                  state_d = WAIT_LO;
               end
            end
            WAIT_LO: begin
               // A byte landing on the expiry cycle still wins over the timeout.
               if (rx_valid) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = addr_q;
                  wr_data_d = rgb565_pack(hi_q, rx_data);
                  if (addr_q == {ADDR_W{1'b1}}) begin
                     state_d = DONE;
                     done_d  = 1'b1;
                  end else begin
                     addr_d  = addr_q + 1'b1;
                     state_d = WAIT_HI;
                  end
               end else if (tmo_expire) begin
                  state_d    = WAIT_HI;
                  sync_err_d = 1'b1;
               end
            end
            DONE: begin
               done_d = 1'b1;
            end
            default: begin
               state_d = WAIT_HI;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= WAIT_HI;
         addr_q     <= '0;
         hi_q       <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         done_q     <= 1'b0;
         sync_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         hi_q       <= hi_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         done_q     <= done_d;
         sync_err_q <= sync_err_d;
      end
   end

   assign wr_en     = wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign load_done = done_q;
   assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_uart_pixel_loader.sv
// Bench for uart_pixel_loader: directed scenarios then random byte streams,
// every cycle compared against a pixel-level reference model.
module tb_uart_pixel_loader;

   localparam int AW   = 4;
   localparam int TO   = 20;
   localparam int NPIX = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clr = 1'b0;
   logic          rx_valid = 1'b0;
   logic [7:0]    rx_data = 8'h00;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [15:0]   wr_data;
   logic          load_done;
   logic          sync_err;

   uart_pixel_loader #(
      .ADDR_W      (AW),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .load_done (load_done),
      .sync_err  (sync_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // Reference model: a pending high byte with its age, next pixel index, full flag.
   bit          m_pend;
   logic [7:0]  m_hi;
   int          m_age;
   int          m_addr;
   bit          m_done;
   bit          e_wr_en;
   int          e_addr;
   logic [15:0] e_data;
   bit          e_sync;
   int          n_writes;

   task automatic model_reset();
      m_pend = 0; m_hi = 0; m_age = 0; m_addr = 0; m_done = 0;
      e_wr_en = 0; e_addr = 0; e_data = 0; e_sync = 0;
   endtask

   task automatic model_step(input bit v, input logic [7:0] d, input bit c);
      e_wr_en = 0;
      e_sync  = 0;
      if (c) begin
         m_pend = 0; m_addr = 0; m_done = 0;
      end else if (m_done) begin
      end else if (m_pend) begin
         if (v) begin
            e_wr_en = 1;
            e_addr  = m_addr;
            e_data  = {m_hi, d};
            m_pend  = 0;
            n_writes++;
            if (m_addr == NPIX - 1) m_done = 1;
            else m_addr++;
         end else begin
            m_age++;
            if (m_age == TO) begin
               m_pend = 0;
               e_sync = 1;
            end
         end
      end else if (v) begin
         m_pend = 1; m_hi = d; m_age = 0;
      end
   endtask

   task automatic compare_all();
      check("wr_en", 32'(wr_en), 32'(e_wr_en));
      check("wr_addr", 32'(wr_addr), 32'(e_addr));
      check("wr_data", 32'(wr_data), 32'(e_data));
      check("load_done", 32'(load_done), 32'(m_done));
      check("sync_err", 32'(sync_err), 32'(e_sync));
   endtask

   task automatic step(input bit v, input logic [7:0] d, input bit c);
      rx_valid = v;
      rx_data  = d;
      clr      = c;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      clr      = 1'b0;
      model_step(v, d, c);
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
   endtask

   task automatic send(input logic [7:0] d);
      step(1'b1, d, 1'b0);
   endtask

   initial begin
      n_writes = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      rst_n = 1'b1;

      // Pixel pairing, back-to-back bytes
      send(8'hF8); send(8'h00);
      check("pair0_wr_en", 32'(wr_en), 32'd1);
      check("pair0_data", 32'(wr_data), 32'hF800);
      send(8'h07); idle(1); send(8'hE0);
      check("pair1_addr", 32'(wr_addr), 32'd1);
      check("pair1_data", 32'(wr_data), 32'h07E0);
      idle(2);

      // Full frame then extra bytes ignored
      step(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 2 * NPIX; i++) begin
         send(8'(i));
         idle(i % 3);
      end
      check("frame_done", 32'(load_done), 32'd1);
      send(8'hAA); idle(1); send(8'hBB); idle(3);
      check("frame_hold", 32'(load_done), 32'd1);

      // Timeout resync
      step(1'b0, 8'h00, 1'b1);
      send(8'hAB); idle(25); send(8'h12); send(8'h34);
      check("resync_data", 32'(wr_data), 32'h1234);
      check("resync_addr", 32'(wr_addr), 32'd0);

      // Boundary race: low byte exactly on the expiry cycle, then one cycle late
      send(8'h9C); idle(TO - 1); send(8'h3D);
      check("race_accept", 32'(wr_en), 32'd1);
      send(8'h11); idle(TO); send(8'h22); send(8'h33);
      idle(2);

      // clr mid-pixel
      step(1'b0, 8'h00, 1'b1);
      for (int p = 0; p < 3; p++) begin send(8'(p)); send(8'(p + 8'h40)); end
      send(8'hC3);
      step(1'b1, 8'h3C, 1'b1);
      check("clr_drop", 32'(wr_en), 32'd0);
      send(8'h55); send(8'hAA);
      check("clr_addr", 32'(wr_addr), 32'd0);
      check("clr_data", 32'(wr_data), 32'h55AA);

      // Asynchronous reset between high and low byte
      send(8'h12); send(8'h34); send(8'h77);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_wr_addr", 32'(wr_addr), 32'd0);
      check("rst_wr_data", 32'(wr_data), 32'd0);
      check("rst_done", 32'(load_done), 32'd0);
      check("rst_sync", 32'(sync_err), 32'd0);
      model_reset();
      #1;
      rst_n = 1'b1;
      idle(1);
      send(8'hDE); send(8'hAD);
      check("rst_next_data", 32'(wr_data), 32'hDEAD);

      // Random streams
      for (int it = 0; it < 1500; it++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 3 || (m_done && r < 30)) begin
            step(1'b0, 8'h00, 1'b1);
         end else if (r < 5) begin
            step(1'b1, 8'($urandom), 1'b1);
         end else begin
            send(8'($urandom));
            if (r < 12) idle(TO - 1);
            else if (r < 18) idle(TO);
            else if (r < 22) idle(TO + int'($urandom_range(1, 4)));
            else idle(int'($urandom_range(0, 3)));
         end
      end
      check("writes_seen", 32'(n_writes > 40), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_pixel_loader.md
# uart_pixel_loader

Receives an RGB565 image as a byte stream from the UART receiver and writes it pixel-by-pixel into the 16-bit image RAM. This is the write side of the image path: the grayscale/transmit path later reads the same memory word-by-word at addresses 0..2^ADDR_W-1. The block pairs bytes into pixels and generates sequential write addresses. It recovers byte alignment with an inter-byte timeout and signals completion when the frame is full.

## Interface
- ADDR_W, 18, RAM address width; frame size is 2^ADDR_W pixels.
- TIMEOUT_CYC, 100000, clk cycles allowed between the high byte and the low byte of one pixel before the high byte is discarded.
- clk  in  1  system clock.
- rst_n  in  1  reset: asynchronous, active-low.
- clr  in  1  synchronous restart: address to 0, state to WAIT_HI, load_done cleared.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in this cycle.
- rx_data  in  8  received byte.
- wr_en  out  1  RAM write strobe, one cycle per pixel.
- wr_addr  out  ADDR_W  RAM write address.
- wr_data  out  16  RGB565 pixel, {high byte, low byte}.
- load_done  out  1  level; high once all 2^ADDR_W pixels are written.
- sync_err  out  1  one-cycle pulse when a timeout discards a pending high byte.

## Operation
- Reset values:
  - wr_en = 0, wr_addr = 0, wr_data = 0, load_done = 0, sync_err = 0.
  - State = WAIT_HI, internal address counter = 0, timeout counter = 0.
- Byte order is big-endian per pixel. The first byte is wr_data[15:8] (R[4:0], G[5:3]); the second byte is wr_data[7:0].
- WAIT_HI:
  - On rx_valid, latch rx_data as the high byte, clear the timeout counter, go to WAIT_LO.
- WAIT_LO:
  - On rx_valid, register wr_data = {hi, rx_data}, wr_addr = address counter, wr_en = 1.
  - If the address counter equals 2^ADDR_W-1, go to DONE. Otherwise increment the address counter and go to WAIT_HI.
  - Without rx_valid, the timeout counter increments. When it reaches TIMEOUT_CYC-1, go to WAIT_HI, pulse sync_err, and leave the address unchanged. The discarded byte is lost.
  - If rx_valid arrives in the same cycle the timeout expires, the byte is accepted and no sync_err is raised.
- DONE:
  - load_done = 1, all rx_valid are ignored, and wr_en stays 0.
  - Leave DONE only by clr or reset.
- clr:
  - Has priority over rx_valid and over the timeout in the same cycle. The coincident byte is dropped and wr_en is forced to 0.
  - Takes effect from any state, including mid-pixel.
- The address counter never wraps. The last write is at 2^ADDR_W-1 and then the block holds in DONE.
- Asynchronous reset mid-frame abandons the partial pixel. No write is issued.

## Timing
- Write latency: wr_en, wr_addr and wr_data are registered and valid in the cycle after the low-byte rx_valid. All three are presented in the same cycle.
- wr_en is never high for two consecutive cycles, because rx_valid strobes are separated by at least one UART frame.
- load_done rises in the same cycle as the final wr_en.
- sync_err is high for exactly one cycle, in the cycle after the timeout counter reaches TIMEOUT_CYC-1.
- Back-to-back rx_valid (one cycle apart) must be accepted: WAIT_HI → WAIT_LO → write with no lost byte.
- The RAM port must accept a write on every cycle that wr_en is high. There is no backpressure.

## Structure
- Shared package holds:
  - state encoding WAIT_HI, WAIT_LO, DONE;
  - default ADDR_W;
  - the RGB565 field positions R[15:11], G[10:5], B[4:0], shared with the grayscale reader.
- One natural sub-module: `byte_timeout`, a loadable down-counter with clear, enable and a one-cycle expire pulse. It is reusable by the future UART command parser.
- The RAM itself is instantiated outside this block. The block exposes only the write port.

## Test plan
- Pixel pairing:
  - Stimulus: bytes 0xF8, 0x00, then 0x07, 0xE0 with ADDR_W=18.
  - Required: writes (addr 0, 0xF800), then (addr 1, 0x07E0), each wr_en one cycle after the second byte.
- Full frame:
  - Stimulus: ADDR_W=4, 32 bytes of incrementing data.
  - Required: 16 writes at addresses 0..15; load_done rises with the write at addr 15.
  - Then send 2 extra bytes. Required: no wr_en, load_done stays 1.
- Timeout resync:
  - Stimulus: TIMEOUT_CYC=20. Send 0xAB, idle 25 cycles, then send 0x12, 0x34.
  - Required: one sync_err pulse at cycle 20 after 0xAB, then a single write (addr 0, 0x1234).
- Boundary race:
  - Stimulus: low byte arrives in exactly the cycle the timeout expires.
  - Required: pixel written, no sync_err.
- clr mid-pixel:
  - Stimulus: after 3 pixels, send a high byte, then assert clr together with the next rx_valid. Then send 0x55, 0xAA.
  - Required: no write for the dropped byte; the next write is (addr 0, 0x55AA).
- Reset mid-frame:
  - Stimulus: assert rst_n low between the high and low byte.
  - Required: all outputs return to reset values asynchronously, no write occurs, and the next pair writes to addr 0.
